// File: rtl/ngp_imem_loader_if.sv
// rtl/ngp_imem_loader_if.sv - program-image loader port bundle for ngp_imem_loader
interface ngp_imem_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic [7:0]        load_byte;
    logic              load_valid;
    logic              load_ready;
    logic              load_done;
    logic              load_err;

    modport master (
        output load_start, load_len, load_byte, load_valid,
        input  load_ready, load_done, load_err
    );

    modport slave (
        input  load_start, load_len, load_byte, load_valid,
        output load_ready, load_done, load_err
    );
endinterface

// File: rtl/ngp_imem_loader.sv
// rtl/ngp_imem_loader.sv - instruction memory with byte-stream program loader for ngp_core
module ngp_imem_loader #(
    parameter int          ADDR_W   = 10,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         addr,
    output logic [15:0]         instruction,
    output logic                core_rst,
    ngp_imem_loader_if.slave    lif
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD_LO, LOAD_HI, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [7:0]        lo_byte;
    logic [ADDR_W:0]   eff_len;
    logic              ready_q;
    logic [15:0]       mem [DEPTH];

    logic              accept;
    logic              last_word;
    logic              wr_en;
    logic              in_range;
    logic [ADDR_W:0]   start_len;

    // A same-cycle load_start wins over the byte, so ready drops for that cycle.
    assign lif.load_ready = ready_q & ~lif.load_start;
    assign accept         = lif.load_valid & lif.load_ready;
    assign start_len      = (lif.load_len > DEPTH_L) ? DEPTH_L : lif.load_len;
    assign last_word      = ({1'b0, wptr} == (eff_len - 1'b1));
    assign wr_en          = (state == LOAD_HI) & accept;
    assign in_range       = ((addr >> ADDR_W) == 16'd0);

    // Load sequencer: restart on load_start from any state, pair bytes little-endian.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            core_rst      <= 1'b1;
            ready_q       <= 1'b0;
            lif.load_done <= 1'b0;
            lif.load_err  <= 1'b0;
            wptr          <= '0;
            lo_byte       <= 8'h00;
            eff_len       <= '0;
        end else begin
            lif.load_done <= 1'b0;
            if (lif.load_start) begin
                wptr         <= '0;
                lo_byte      <= 8'h00;
                eff_len      <= start_len;
                lif.load_err <= (lif.load_len > DEPTH_L);
                if (start_len == '0) begin
                    state         <= RUN;
                    core_rst      <= 1'b0;
                    ready_q       <= 1'b0;
                    lif.load_done <= 1'b1;
                end else begin
                    state    <= LOAD_LO;
                    core_rst <= 1'b1;
                    ready_q  <= 1'b1;
                end
            end else begin
                case (state)
                    LOAD_LO: begin
                        if (accept) begin
                            lo_byte <= lif.load_byte;
                            state   <= LOAD_HI;
                        end
                    end
                    LOAD_HI: begin
                        if (accept) begin
                            wptr <= wptr + 1'b1;
                            if (last_word) begin
                                state         <= RUN;
                                core_rst      <= 1'b0;
                                ready_q       <= 1'b0;
                                lif.load_done <= 1'b1;
                            end else begin
                                state <= LOAD_LO;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Program memory write port; contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= {lif.load_byte, lo_byte};
        end
    end

    // Registered fetch: NOP unless running and the address lies inside memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction <= NOP_WORD;
        end else if ((state == RUN) && in_range) begin
            instruction <= mem[addr[ADDR_W-1:0]];
        end else begin
            instruction <= NOP_WORD;
        end
    end
endmodule

// File: tb/tb_ngp_imem_loader.sv
// tb/tb_ngp_imem_loader.sv - directed self-checking bench for ngp_imem_loader
module tb_ngp_imem_loader;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] instruction;
    logic        core_rst;
    int          checks = 0;
    int          errors = 0;

    ngp_imem_loader_if #(.ADDR_W(ADDR_W)) lif ();

    ngp_imem_loader #(.ADDR_W(ADDR_W), .NOP_WORD(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .instruction (instruction),
        .core_rst    (core_rst),
        .lif         (lif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after load_start was seen.
    task automatic start_load(input int len);
        lif.load_start = 1'b1;
        lif.load_len   = (ADDR_W + 1)'(len);
        #1;
        chk("ready_low_in_start_cycle", {31'd0, lif.load_ready}, 32'd0);
        @(negedge clk);
        lif.load_start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit got;
        if (gap) @(negedge clk);
        lif.load_byte  = b;
        lif.load_valid = 1'b1;
        #1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (lif.load_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        lif.load_valid = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [15:0] a, input logic [15:0] exp);
        addr = a;
        @(negedge clk);
        chk(tag, {16'd0, instruction}, {16'd0, exp});
    endtask

    initial begin
        rst            = 1'b1;
        addr           = 16'd0;
        lif.load_start = 1'b0;
        lif.load_len   = '0;
        lif.load_byte  = 8'h00;
        lif.load_valid = 1'b0;
        repeat (2) @(negedge clk);

        // 1. reset state
        chk("rst_instruction", {16'd0, instruction}, 32'h0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_ready", {31'd0, lif.load_ready}, 32'd0);
        chk("rst_err", {31'd0, lif.load_err}, 32'd0);
        chk("rst_done", {31'd0, lif.load_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 2. back-to-back two-word load
        start_load(2);
        chk("t2_core_rst_loading", {31'd0, core_rst}, 32'd1);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hCD, 1'b0);
        chk("t2_no_early_done", {31'd0, lif.load_done}, 32'd0);
        send_byte(8'hAB, 1'b0);
        chk("t2_done", {31'd0, lif.load_done}, 32'd1);
        chk("t2_core_run", {31'd0, core_rst}, 32'd0);
        chk("t2_ready_run", {31'd0, lif.load_ready}, 32'd0);
        fetch("t2_fetch1", 16'd1, 16'hABCD);
        chk("t2_done_pulse", {31'd0, lif.load_done}, 32'd0);
        fetch("t2_fetch0", 16'd0, 16'h1234);

        // 3. same load with gapped valid
        start_load(2);
        chk("t3_core_rst_reassert", {31'd0, core_rst}, 32'd1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'hCD, 1'b1);
        chk("t3_no_early_done", {31'd0, lif.load_done}, 32'd0);
        send_byte(8'hAB, 1'b1);
        chk("t3_done", {31'd0, lif.load_done}, 32'd1);
        fetch("t3_fetch0", 16'd0, 16'h1234);
        fetch("t3_fetch1", 16'd1, 16'hABCD);

        // 4. oversize load: word i = {80|i, i}
        start_load(DEPTH + 5);
        chk("t4_err", {31'd0, lif.load_err}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'(i), 1'b0);
            send_byte(8'(8'h80 | i), 1'b0);
            chk("t4_done_timing", {31'd0, lif.load_done}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
        end
        chk("t4_core_run", {31'd0, core_rst}, 32'd0);
        chk("t4_err_sticky", {31'd0, lif.load_err}, 32'd1);
        fetch("t4_fetch_depth", 16'(DEPTH), 16'h0000);
        fetch("t4_fetch_last", 16'(DEPTH - 1), 16'h8F0F);
        fetch("t4_fetch_high_bit", 16'h8000, 16'h0000);
        fetch("t4_fetch_first", 16'd0, 16'h8000);

        // 5. restart mid-load, with a same-cycle byte that must be dropped
        start_load(2);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        lif.load_valid = 1'b1;
        lif.load_byte  = 8'hFF;
        start_load(1);
        lif.load_valid = 1'b0;
        chk("t5_err_cleared", {31'd0, lif.load_err}, 32'd0);
        chk("t5_nop_while_loading", {16'd0, instruction}, 32'h0);
        send_byte(8'h34, 1'b0);
        chk("t5_no_early_done", {31'd0, lif.load_done}, 32'd0);
        send_byte(8'h12, 1'b0);
        chk("t5_done", {31'd0, lif.load_done}, 32'd1);
        fetch("t5_fetch0", 16'd0, 16'h1234);
        fetch("t5_fetch1_untouched", 16'd1, 16'h8101);

        // 6. reset while in LOAD_HI keeps memory
        start_load(2);
        send_byte(8'h56, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_core_rst", {31'd0, core_rst}, 32'd1);
        chk("t6_ready", {31'd0, lif.load_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_load(0);
        chk("t6_len0_done", {31'd0, lif.load_done}, 32'd1);
        chk("t6_len0_run", {31'd0, core_rst}, 32'd0);
        fetch("t6_fetch0_retained", 16'd0, 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
